// File: rtl/inst_fetch_axi.sv
// -----------------------------------------------------------------------------
// inst_fetch_axi
//
// Instruction fetch unit that talks to memory over an AXI read channel.
// Each fetch is one 4-byte INCR beat, and only one fetch is in flight at a time.
// A fetch starts when the downstream stage asks for the next instruction. The
// fetched word comes back as a one-cycle valid strobe, together with its PC and
// an exception code. A flush redirects the PC. If a request is already on the
// bus when the flush arrives, that request still completes and its data is
// thrown away.
//
// Ports
//   clk              clock, all logic on posedge
//   rst              asynchronous reset, active low
//   flush, new_pc    redirect request and target PC
//   next_pc_valid    downstream ready for the next instruction
//   ar*              AXI read-address channel (constant id/len/size/burst)
//   r*               AXI read-data channel (rid and rlast are not used)
//   valid            one-cycle strobe qualifying if_pc / if_inst / pc_excepttype_o
//   if_pc, if_inst   fetched PC and instruction word
//   pc_excepttype_o  0 = ok, 4 = AdEL (misaligned PC), 8 = bus error
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no transaction; waits for next_pc_valid
// ADDR    | arvalid asserted, waiting for arready
// DATA    | address accepted, waiting for the R beat to deliver
// DISCARD | address accepted after a flush, R beat will be dropped
// -----------------------------------------------------------------------------
module inst_fetch_axi #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [3:0]  FETCH_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        next_pc_valid,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] pc_excepttype_o
);

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_BUS  = 32'h0000_0008;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pending;   // flush seen while the address was still waiting for arready

    // Single-beat read: the beat count is fixed, so rid/rlast carry no information.
    logic unused_in;
    assign unused_in = ^{rid, rlast};

    assign arid    = FETCH_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Decoded straight from the state register, so it is glitch-free.
    assign rready  = (state == DATA) || (state == DISCARD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            pending         <= 1'b0;
            arvalid         <= 1'b0;
            araddr          <= 32'h0;
            valid           <= 1'b0;
            if_pc           <= 32'h0;
            if_inst         <= 32'h0;
            pc_excepttype_o <= 32'h0;
        end else begin
            valid <= 1'b0;
            if (flush) begin
                pc <= new_pc;
            end

            case (state)
                IDLE: begin
                    if (!flush && next_pc_valid) begin
                        if (pc[1:0] == 2'b00) begin
                            state   <= ADDR;
                            arvalid <= 1'b1;
                            araddr  <= pc;
                        end else begin
                            // Misaligned PC: report AdEL without touching the bus.
                            valid           <= 1'b1;
                            if_pc           <= pc;
                            if_inst         <= 32'h0;
                            pc_excepttype_o <= EXC_ADEL;
                        end
                    end
                end

                ADDR: begin
                    // arvalid cannot be withdrawn, so a flush here only marks
                    // the coming beat for discard.
                    if (arready) begin
                        arvalid <= 1'b0;
                        pending <= 1'b0;
                        state   <= (pending || flush) ? DISCARD : DATA;
                    end else if (flush) begin
                        pending <= 1'b1;
                    end
                end

                DATA: begin
                    if (flush) begin
                        // A beat arriving with the flush is consumed right here.
                        state <= rvalid ? IDLE : DISCARD;
                    end else if (rvalid) begin
                        valid <= 1'b1;
                        if_pc <= araddr;
                        if (rresp == 2'b00) begin
                            if_inst         <= rdata;
                            pc_excepttype_o <= EXC_NONE;
                        end else begin
                            if_inst         <= 32'h0;
                            pc_excepttype_o <= EXC_BUS;
                        end
                        pc    <= pc + 32'd4;
                        state <= IDLE;
                    end
                end

                DISCARD: begin
                    if (rvalid) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
module tb_inst_fetch_axi;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        next_pc_valid = 1'b0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'h0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b1;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] pc_excepttype_o;

    always #5 clk = ~clk;

    inst_fetch_axi #(.RESET_PC(RESET_PC), .FETCH_ID(4'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc),
        .next_pc_valid(next_pc_valid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .valid(valid), .if_pc(if_pc), .if_inst(if_inst),
        .pc_excepttype_o(pc_excepttype_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: the PC the fetcher should be on, whether an
    // address request is on the bus, whether a beat is owed, and whether that
    // beat was cancelled by a redirect.
    logic [31:0] m_pc, m_addr;
    logic        req_open, beat_owed, m_drop;
    logic        exp_valid;
    logic [31:0] e_pc, e_inst, e_exc;

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_addr    = 32'h0;
        req_open  = 1'b0;
        beat_owed = 1'b0;
        m_drop    = 1'b0;
        exp_valid = 1'b0;
        e_pc      = 32'h0;
        e_inst    = 32'h0;
        e_exc     = 32'h0;
    endtask

    task automatic step(input logic fl, input logic [31:0] npc, input logic npv,
                        input logic ar, input logic rv, input logic [31:0] rd,
                        input logic [1:0] rr);
        @(negedge clk);
        check_val("valid",   32'(valid), 32'(exp_valid));
        check_val("if_pc",   if_pc, e_pc);
        check_val("if_inst", if_inst, e_inst);
        check_val("exc",     pc_excepttype_o, e_exc);
        check_val("arvalid", 32'(arvalid), 32'(req_open));
        if (req_open) check_val("araddr", araddr, m_addr);
        check_val("rready",  32'(rready), 32'(beat_owed));

        flush = fl; new_pc = npc; next_pc_valid = npv; arready = ar;
        rvalid = rv; rdata = rd; rresp = rr; rid = 4'($urandom); rlast = 1'b1;

        exp_valid = 1'b0;
        if (!req_open && !beat_owed) begin
            if (fl) m_pc = npc;
            else if (npv) begin
                if (m_pc[1:0] != 2'b00) begin
                    exp_valid = 1'b1; e_pc = m_pc; e_inst = 32'h0; e_exc = 32'h4;
                end else begin
                    req_open = 1'b1; m_addr = m_pc; m_drop = 1'b0;
                end
            end
        end else if (req_open) begin
            if (fl) begin m_pc = npc; m_drop = 1'b1; end
            if (ar) begin req_open = 1'b0; beat_owed = 1'b1; end
        end else begin
            if (fl) begin m_pc = npc; m_drop = 1'b1; end
            if (rv) begin
                beat_owed = 1'b0;
                if (!m_drop) begin
                    exp_valid = 1'b1;
                    e_pc      = m_addr;
                    e_inst    = (rr == 2'b00) ? rd : 32'h0;
                    e_exc     = (rr == 2'b00) ? 32'h0 : 32'h8;
                    m_pc      = m_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic idle_in(input logic npv);
        step(1'b0, 32'h0, npv, 1'b0, 1'b0, 32'h0, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check_val("rst_arvalid", 32'(arvalid), 32'h0);
        check_val("rst_rready",  32'(rready), 32'h0);
        check_val("rst_valid",   32'(valid), 32'h0);
        check_val("rst_if_pc",   if_pc, 32'h0);
        check_val("rst_if_inst", if_inst, 32'h0);
        check_val("rst_exc",     pc_excepttype_o, 32'h0);
        model_reset();
        flush = 0; next_pc_valid = 0; arready = 0; rvalid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] npc;
        int r;
        model_reset();
        do_reset();
        check_val("arid",    32'(arid), 32'h0);
        check_val("arlen",   32'(arlen), 32'h0);
        check_val("arsize",  32'(arsize), 32'h2);
        check_val("arburst", 32'(arburst), 32'h1);

        // Basic fetch with 5 cycles of address backpressure
        idle_in(1'b1);
        for (int i = 0; i < 5; i++) begin
            idle_in(1'b0);
            check_val("bp_arvalid", 32'(arvalid), 32'h1);
            check_val("bp_araddr", araddr, 32'hBFC0_0000);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h2408_0001, 2'b00);
        idle_in(1'b0);
        check_val("basic_valid", 32'(valid), 32'h1);
        check_val("basic_pc", if_pc, 32'hBFC0_0000);
        check_val("basic_inst", if_inst, 32'h2408_0001);
        idle_in(1'b1);
        check_val("one_pulse", 32'(valid), 32'h0);
        step(0, 0, 0, 1, 0, 0, 0);
        check_val("next_addr", araddr, 32'hBFC0_0004);

        // Flush in DATA, late beat dropped
        step(1, 32'hBFC0_0380, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        idle_in(1'b1);
        check_val("data_flush_novalid", 32'(valid), 32'h0);
        step(0, 0, 0, 1, 0, 0, 0);
        check_val("data_flush_addr", araddr, 32'hBFC0_0380);

        // Bus error
        step(0, 0, 0, 0, 1, 32'h1234_5678, 2'b10);
        idle_in(1'b1);
        check_val("buserr_valid", 32'(valid), 32'h1);
        check_val("buserr_inst", if_inst, 32'h0);
        check_val("buserr_exc", pc_excepttype_o, 32'h8);

        // Flush while address is stalled
        step(1, 32'hBFC0_1000, 0, 0, 0, 0, 0);
        idle_in(1'b0);
        check_val("addr_flush_hold", 32'(arvalid), 32'h1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hCAFE_0000, 0);
        idle_in(1'b1);
        check_val("addr_flush_novalid", 32'(valid), 32'h0);
        step(0, 0, 0, 1, 0, 0, 0);
        check_val("addr_flush_addr", araddr, 32'hBFC0_1000);
        step(0, 0, 0, 0, 1, 32'h0000_1111, 0);

        // Misaligned PC
        step(1, 32'h0000_0002, 0, 0, 0, 0, 0);
        idle_in(1'b1);
        idle_in(1'b0);
        check_val("adel_valid", 32'(valid), 32'h1);
        check_val("adel_exc", pc_excepttype_o, 32'h4);
        check_val("adel_pc", if_pc, 32'h0000_0002);
        check_val("adel_noreq", 32'(arvalid), 32'h0);

        // Wrap
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        idle_in(1'b1);
        step(0, 0, 0, 1, 0, 0, 0);
        check_val("wrap_addr0", araddr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 32'h0000_2222, 0);
        idle_in(1'b1);
        step(0, 0, 0, 1, 0, 0, 0);
        check_val("wrap_addr1", araddr, 32'h0000_0000);
        step(0, 0, 0, 0, 1, 32'h0000_3333, 0);

        // Randomized traffic with a mid-run reset
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                do_reset();
                for (int k = 0; k < 3; k++) idle_in(1'b0);
            end
            r = $urandom_range(0, 9);
            npc = $urandom;
            if (r == 0) npc[1:0] = 2'($urandom_range(1, 3));
            else if (r == 1) npc = 32'hFFFF_FFFC;
            else npc[1:0] = 2'b00;
            step(($urandom_range(0, 11) == 0), npc, ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), beat_owed && ($urandom_range(0, 9) < 4),
                 $urandom, ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        idle_in(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_axi.md
INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FETCH_ID, default 4'h0, meaning the constant value driven on arid.
REQ-003 SHALL have ports as follows.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard in-flight fetch and redirect.
- new_pc  in  32  redirect target, sampled when flush=1.
- next_pc_valid  in  1  downstream IF/ID register ready for the next instruction.
- arid  out  4  AXI read ID.
- araddr  out  32  AXI read address.
- arlen  out  8  burst length.
- arsize  out  3  burst size.
- arburst  out  2  burst type.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- rid  in  4  read ID (ignored).
- rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat (ignored; single beat).
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- valid  out  1  one-cycle strobe; if_pc and if_inst are valid.
- if_pc  out  32  fetched PC.
- if_inst  out  32  fetched instruction.
- pc_excepttype_o  out  32  fetch exception code accompanying valid.

Function
REQ-004 SHALL drive constants arid=FETCH_ID, arlen=0, arsize=3'b010, arburst=2'b01 (single 4-byte INCR beat).
REQ-005 SHALL implement an FSM with states IDLE, ADDR, DATA and DISCARD, and SHALL hold an internal 32-bit pc register.
REQ-006 In IDLE with next_pc_valid=1, flush=0 and pc[1:0]=0, the FSM SHALL go to ADDR and assert arvalid with araddr=pc on the next cycle; in IDLE, next_pc_valid=0 SHALL leave the FSM in IDLE.
REQ-007 next_pc_valid SHALL be ignored in every state other than IDLE.
REQ-008 In IDLE with next_pc_valid=1 and pc[1:0]!=0, the block SHALL issue no AXI request and SHALL, next cycle, pulse valid with if_pc=pc, if_inst=0 and pc_excepttype_o=32'h0000_0004 (AdEL), with pc unchanged.
REQ-009 In ADDR, arvalid and araddr SHALL stay stable until arvalid&&arready; the FSM SHALL then go to DATA, or to DISCARD if a flush is pending.
REQ-010 rready SHALL be 1 exactly in DATA and DISCARD.
REQ-011 In DATA, on rvalid=1 with flush=0, the block SHALL:
- pulse valid for one cycle next cycle, with if_pc=request address and if_inst=rdata;
- drive pc_excepttype_o=0 when rresp=2'b00, or if_inst=0 and pc_excepttype_o=32'h0000_0008 (bus error) otherwise;
- set pc<=pc+4, with modulo 2^32 wrap (32'hFFFF_FFFC -> 0);
- return to IDLE.
REQ-012 valid SHALL be high for exactly one cycle per delivered fetch; if_pc, if_inst and pc_excepttype_o SHALL hold their last values while valid=0.
REQ-013 On flush=1 in any state: pc<=new_pc, and valid SHALL be 0 in the following cycle.
- IDLE: stay in IDLE.
- ADDR: keep arvalid asserted (AXI forbids withdrawal) and set the pending flag.
- DATA: go to DISCARD, or to IDLE if rvalid=1 in that same cycle.
- DISCARD: stay in DISCARD.
REQ-014 DISCARD SHALL accept one R beat without asserting valid, then go to IDLE.
REQ-015 Latency SHALL be: next_pc_valid at cycle N gives arvalid at N+1; rvalid at cycle K gives valid at K+1; at most one transaction is outstanding.

Reset
REQ-016 While rst=0, regardless of clk: state=IDLE, pc=RESET_PC, arvalid=0, rready=0, valid=0, if_pc=0, if_inst=0, pc_excepttype_o=0, pending flag cleared.
REQ-017 An assertion of rst mid-transaction SHALL abandon the transaction; after release the block SHALL wait for next_pc_valid before issuing any request.

Verification
REQ-018 Basic fetch: release reset, next_pc_valid=1, arready=1, rvalid with rdata=32'h2408_0001 and rresp=0 -> araddr=32'hBFC0_0000, then valid=1 with if_pc=32'hBFC0_0000, if_inst=32'h2408_0001, then next araddr=32'hBFC0_0004.
REQ-019 Backpressure: hold arready=0 for 5 cycles -> arvalid and araddr stable throughout; exactly one valid pulse after the R beat.
REQ-020 Flush in DATA: flush=1 with new_pc=32'hBFC0_0380 before rvalid -> the late beat is consumed with no valid pulse, and the next araddr=32'hBFC0_0380.
REQ-021 Flush in ADDR: flush while arready=0 -> arvalid held until handshake, the R beat is discarded, and the next fetch is from new_pc.
REQ-022 Errors: rresp=2'b10 -> valid with if_inst=0 and pc_excepttype_o=32'h0000_0008; flush to new_pc=32'h0000_0002 then next_pc_valid -> no arvalid, valid with pc_excepttype_o=32'h0000_0004.
REQ-023 Wrap: flush to 32'hFFFF_FFFC, complete one fetch -> next araddr=32'h0000_0000.
